// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and state encoding for the countdown timer
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot and auto-reload modes
module timer_dev
  import timer_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_e             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pend_q, pend_d;

  logic       en;
  logic       im;
  logic       reload_mode;

  assign en          = ctrl_q[CTRL_EN];
  assign im          = ctrl_q[CTRL_IM];
  assign reload_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          state_d = ST_INT;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (reload_mode) begin
          state_d = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          pend_d          = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes come last so they override the FSM's EN clear and pend set.
    if (we) begin
      if (addr == ADDR_CTRL) begin
        ctrl_d = din[CTRL_W-1:0];
        pend_d = 1'b0;
      end else if (addr == ADDR_PRESET) begin
        preset_d = din[CNT_W-1:0];
        pend_d   = 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    if (reload_mode) begin
      irq = im & (state_q == ST_INT);
    end else begin
      irq = im & pend_q;
    end
    case (addr)
      ADDR_CTRL:   dout = 32'(ctrl_q);
      ADDR_PRESET: dout = 32'(preset_q);
      ADDR_COUNT:  dout = 32'(count_q);
      default:     dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed self-checking bench for timer_dev
module tb_timer_dev;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int vectors;
  int miscompares;

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    din  = '0;
    step(2);
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    step(1);

    // One-shot: PRESET=3, irq rises six edges after the CTRL write edge
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    step(2);
    rd("os_cnt3", 2'd2, 32'd3);
    step(1);
    rd("os_cnt2", 2'd2, 32'd2);
    step(1);
    rd("os_cnt1", 2'd2, 32'd1);
    step(1);
    rd("os_cnt0", 2'd2, 32'd0);
    check("os_irq_pre", {31'b0, irq}, 32'h0);
    step(1);
    check("os_irq_edge6", {31'b0, irq}, 32'h1);
    rd("os_ctrl_after", 2'd0, 32'h8);
    step(3);
    check("os_irq_held", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'h0);
    check("os_irq_clear", {31'b0, irq}, 32'h0);

    // Auto-reload: PRESET=2, one-cycle pulse every 4 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check($sformatf("ar_irq_c%0d", k), {31'b0, irq}, {31'b0, (k % 4 == 0)});
    end
    rd("ar_ctrl", 2'd0, 32'hB);

    // Collision: CTRL write lands in the INT cycle
    wr(2'd0, 32'h8);
    check("col_irq", {31'b0, irq}, 32'h0);
    rd("col_ctrl", 2'd0, 32'h8);
    wr(2'd2, 32'hFFFF);
    for (int k = 0; k < 6; k++) begin
      step(1);
      check($sformatf("col_quiet_%0d", k), {31'b0, irq}, 32'h0);
    end
    rd("col_count", 2'd2, 32'd2);

    // Masked one-shot: pend sets but irq stays low
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    step(4);
    check("mask_irq", {31'b0, irq}, 32'h0);
    check("mask_pend", {31'b0, dut.pend_q}, 32'h1);
    rd("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    check("mask_irq_after", {31'b0, irq}, 32'h0);
    check("mask_pend_clr", {31'b0, dut.pend_q}, 32'h0);

    // Stop mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(6);
    rd("stop_cnt6", 2'd2, 32'd6);
    wr(2'd0, 32'h8);
    rd("stop_cnt5", 2'd2, 32'd5);
    step(3);
    rd("stop_frozen", 2'd2, 32'd5);
    check("stop_irq", {31'b0, irq}, 32'h0);

    // PRESET=0: irq after four edges
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(3);
    check("p0_irq_pre", {31'b0, irq}, 32'h0);
    step(1);
    check("p0_irq", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'h0);

    // Reset in the middle of an auto-reload count
    wr(2'd1, 32'd7);
    wr(2'd0, 32'hB);
    step(3);
    rst = 1'b1;
    #1;
    check("mrst_irq", {31'b0, irq}, 32'h0);
    step(2);
    rst = 1'b0;
    rd("mrst_ctrl", 2'd0, 32'h0);
    rd("mrst_preset", 2'd1, 32'h0);
    rd("mrst_count", 2'd2, 32'h0);
    rd("mrst_addr3", 2'd3, 32'h0);
    step(3);
    check("mrst_irq_after", {31'b0, irq}, 32'h0);
    rd("mrst_count_after", 2'd2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped programmable countdown timer on the system bus.
- Its `irq` output drives the coprocessor-0 hardware interrupt input HWint[2].
- The CPU configures it through three word registers and services its interrupt via the CP0 exception path.
- Two modes: one-shot (mode 0) with a level interrupt, and auto-reload (mode 1) with a one-cycle interrupt pulse.

Parameters:
- `CTRL_W`, 4, number of implemented CTRL bits.
- `CNT_W`, 32, width of PRESET and COUNT.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset.
- `addr`  in  2  word address, byte address bits [3:2]. 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
- `we`  in  1  bus write strobe, sampled on rising clk.
- `din`  in  32  bus write data.
- `dout`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request to CP0 HWint[2].

Interface decision: reset `rst` is asynchronous and active-high; clock is `clk`.

Behaviour:
- **Reset:**
  - CTRL=0, PRESET=0, COUNT=0, pend=0, state=IDLE.
  - Hence `irq`=0, and `dout`=0 for addr 0 and 2.
  - Assertion mid-count aborts immediately; no interrupt is generated.
- **CTRL layout:**
  - bit0 EN (enable).
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload, 10/11 behave as 00.
  - bit3 IM (interrupt mask, 1 = enabled).
  - bits[31:4] read 0 and ignore writes.
- **Writes (`we`=1):**
  - addr0 writes CTRL[3:0] and clears pend.
  - addr1 writes PRESET and clears pend.
  - addr2 and addr3 are ignored; COUNT is read-only.
- **Read mux:** addr0 gives {28'b0, CTRL}; addr1 gives PRESET; addr2 gives COUNT; addr3 gives 0.
- **FSM states:** IDLE, LOAD, CNT, INT. Transitions on rising clk:
  - IDLE: if EN, go to LOAD; else stay.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT:
    - if !EN, go to IDLE (COUNT holds its value);
    - else if COUNT<=1, COUNT<=0 and go to INT (PRESET=0 reaches INT after a single CNT cycle);
    - else COUNT<=COUNT-1.
  - INT, mode 0: EN<=0, pend<=1, go to IDLE.
  - INT, mode 1: go to LOAD; EN is unchanged.
- **irq:**
  - mode 0: `irq` = IM & pend. Level output, held until software writes CTRL or PRESET.
  - mode 1: `irq` = IM & (state==INT). Exactly one cycle per period.
- **Latency:**
  - Mode 0: `irq` rises PRESET+3 edges after the CTRL write edge (for PRESET>=1).
  - Mode 1: period is PRESET+2 cycles.
- **Simultaneous events:**
  - A bus write to CTRL in the same cycle as INT overrides the FSM's EN<=0; the bus value wins.
  - That same write's pend-clear also wins over pend-set.
- **Mid-count writes:**
  - A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
  - A CTRL write with EN=0 during CNT stops the count on the next edge.
- **Arithmetic:** unsigned decrement; COUNT never wraps below 0.

Decomposition:
- Package `timer_pkg` holds:
  - address constants ADDR_CTRL=2'd0, ADDR_PRESET=2'd1, ADDR_COUNT=2'd2;
  - mode constants MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01;
  - CTRL bit-index constants;
  - the 2-bit state encoding IDLE/LOAD/CNT/INT.
- No sub-module: register file, FSM and read mux stay in a single module.

Test Plan:
- **Reset:** assert `rst` for 2 cycles mid-operation -> `dout`=0 for all addr, `irq`=0, COUNT=0.
- **One-shot:** PRESET=3, CTRL=0x9 -> COUNT reads 3,2,1,0; `irq`=1 six edges after the CTRL write; CTRL reads 0x8 afterwards. A later write of CTRL=0x0 drops `irq` next cycle.
- **Auto-reload:** PRESET=2, CTRL=0xB -> `irq` pulses of 1 cycle, period 4 cycles, over 5 periods; CTRL stays 0xB.
- **Masked:** PRESET=1, CTRL=0x1 -> `irq` stays 0; pend is set internally; a subsequent write of CTRL=0x8 leaves `irq`=0 (pend cleared by that write).
- **Stop/PRESET-0:**
  - CTRL=0x9 with PRESET=10, write CTRL=0x8 when COUNT=6 -> COUNT frozen at 5, no `irq`.
  - PRESET=0, CTRL=0x9 -> `irq` after 4 edges.
- **Collision:** in mode 1, write CTRL=0x8 in the INT cycle -> EN=0, FSM returns to LOAD then IDLE, no further pulses; COUNT write (addr2, 0xFFFF) is ignored.
